// File: rtl/pe_col_sched.sv
// rtl/pe_col_sched.sv - scheduler for a 3-PE psum-chained convolution column
// Sequences kernel load, ifmap streaming, pipeline drain and valid/ready result hand-off.
module pe_col_sched #(
  parameter int IMG_W    = 32,
  parameter int NUM_ROWS = 30,
  parameter int PE_LAT   = 2,
  parameter int PSUM_W   = 14
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [35:0]       i_cfg_filt,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [23:0]       i_s_data,
  output logic              o_pe_en,
  output logic [23:0]       o_pe_ifmap,
  output logic [35:0]       o_pe_filt,
  output logic [PSUM_W-1:0] o_pe_psum_in,
  input  logic [PSUM_W-1:0] i_pe_psum_out,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [PSUM_W-1:0] o_m_data
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(NUM_ROWS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PE_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [DW-1:0]       r_drain;
  logic [PE_LAT-1:0]   r_tag;
  logic [PE_LAT-1:0]   w_tag_next;
  logic [35:0]         r_filt;
  logic                r_m_valid;
  logic [PSUM_W-1:0]   r_m_data;
  logic                w_out_ok;
  logic                w_adv;
  logic                w_tag_in;
  logic                w_last_beat;

  assign w_out_ok    = !r_m_valid || i_m_ready;
  assign w_last_beat = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_tag_next  = (r_tag << 1) | PE_LAT'(w_tag_in);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_s_ready    = 1'b0;
    w_adv        = 1'b0;
    w_tag_in     = 1'b0;
    o_pe_ifmap   = '0;
    case (r_state)
      S_IDLE: if (i_start) w_state_next = S_LOAD;
      S_LOAD: begin
        o_busy       = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        o_busy     = 1'b1;
        o_s_ready  = w_out_ok;
        w_adv      = w_out_ok && i_s_valid;
        o_pe_ifmap = i_s_data;
        // first two columns of each row only warm up the tap window
        w_tag_in   = (r_col >= CW'(2));
        if (w_adv && w_last_beat) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        w_adv  = w_out_ok;
        if (w_adv && (r_drain == DRAIN_LAST)) w_state_next = S_DONE;
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_drain   <= '0;
      r_tag     <= '0;
      r_filt    <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      if (r_state == S_LOAD) begin
        r_filt  <= i_cfg_filt;
        r_col   <= '0;
        r_row   <= '0;
        r_drain <= '0;
      end
      if (w_adv) r_tag <= w_tag_next;
      if (w_adv && (r_state == S_RUN)) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_adv && (r_state == S_DRAIN))
        r_drain <= (r_drain == DRAIN_LAST) ? '0 : r_drain + DW'(1);
      // a fresh capture wins over an accept so back-to-back results need no bubble
      if (w_adv && r_tag[PE_LAT-1]) begin
        r_m_data  <= i_pe_psum_out;
        r_m_valid <= 1'b1;
      end else if (i_m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign o_pe_en      = w_adv;
  assign o_pe_filt    = r_filt;
  assign o_pe_psum_in = '0;
  assign o_m_valid    = r_m_valid;
  assign o_m_data     = r_m_data;

endmodule
